// File: rtl/simon_pkt_out_fifo_if.sv
// Handshake bundle for the SIMON output packetiser: block input stream from the
// round core and packet output stream towards the downstream interface.
interface simon_pkt_out_fifo_if #(
  parameter int N      = 16,
  parameter int BLOCKS = 2
);
  localparam int PW = 16 + BLOCKS * 2 * N;

  logic              data_valid;
  logic [2*N-1:0]    data_in;
  logic [7:0]        info_in;
  logic [7:0]        count_in;
  logic              data_ready;
  logic              pkt_valid;
  logic [PW-1:0]     pkt_out;
  logic              pkt_ready;

  modport slave (
    input  data_valid, data_in, info_in, count_in, pkt_ready,
    output data_ready, pkt_valid, pkt_out
  );

  modport master (
    output data_valid, data_in, info_in, count_in, pkt_ready,
    input  data_ready, pkt_valid, pkt_out
  );
endinterface

// File: rtl/simon_pkt_out_fifo.sv
// SIMON output packetiser: validates headers, assembles {info, count, blocks}
// packets and queues them in a shift-register FIFO with a registered head.
module simon_pkt_out_fifo #(
  parameter int         N      = 16,
  parameter int         BLOCKS = 2,
  parameter int         DEPTH  = 2,
  parameter logic [3:0] MODE   = 4'h0
) (
  input  logic                   clk,
  input  logic                   nR,
  simon_pkt_out_fifo_if.slave    bus,
  input  logic                   err_clr,
  output logic                   err_count,
  output logic                   err_mode,
  output logic                   err_dir,
  output logic [$clog2(DEPTH):0] level
);
  localparam int BW   = 2 * N;
  localparam int BLKW = BLOCKS * BW;
  localparam int PW   = 16 + BLKW;
  localparam int LW   = $clog2(DEPTH) + 1;
  localparam int IW   = $clog2(BLOCKS + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PUSH    = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [7:0]      info_r, info_nxt_s;
  logic [7:0]      count_r, count_nxt_s;
  logic [7:0]      exp_r, exp_nxt_s;
  logic [BLKW-1:0] blk_r, blk_nxt_s;
  logic [IW-1:0]   idx_r, idx_nxt_s;
  logic            err_count_r, err_count_nxt_s;
  logic            err_mode_r, err_mode_nxt_s;
  logic            err_dir_r, err_dir_nxt_s;
  logic            data_ready_r;

  logic [PW-1:0]   fifo_r     [DEPTH];
  logic [PW-1:0]   fifo_nxt_s [DEPTH];
  logic [PW-1:0]   fifo_up_s  [DEPTH];
  logic [LW-1:0]   level_r, level_nxt_s;
  logic [LW-1:0]   wr_idx_s;
  logic            pkt_valid_r;

  logic            accept_s;
  logic            full_s;
  logic            pop_s;
  logic            push_s;
  logic [PW-1:0]   pkt_s;

  assign accept_s = bus.data_valid & data_ready_r;
  assign full_s   = (level_r == LW'(DEPTH));
  assign pop_s    = pkt_valid_r & bus.pkt_ready;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign push_s   = (state_r == ST_PUSH) & (~full_s | pop_s);
  assign pkt_s    = {info_r, count_r, blk_r};

  // Header checks, block collection and FSM next-state decode.
  always_comb begin
    state_nxt_s     = state_r;
    info_nxt_s      = info_r;
    count_nxt_s     = count_r;
    exp_nxt_s       = exp_r;
    blk_nxt_s       = blk_r;
    idx_nxt_s       = idx_r;
    err_count_nxt_s = err_clr ? 1'b0 : err_count_r;
    err_mode_nxt_s  = err_clr ? 1'b0 : err_mode_r;
    err_dir_nxt_s   = err_clr ? 1'b0 : err_dir_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (bus.count_in != exp_r) begin
            err_count_nxt_s = 1'b1;
          end else if (bus.info_in[3:0] != MODE) begin
            err_mode_nxt_s = 1'b1;
          end else if (!bus.info_in[4]) begin
            err_dir_nxt_s = 1'b1;
          end else begin
            info_nxt_s  = bus.info_in;
            count_nxt_s = bus.count_in;
            exp_nxt_s   = exp_r + 8'd1;
            blk_nxt_s   = '0;
            if (bus.info_in[5]) begin
              state_nxt_s = ST_PUSH;
            end else begin
              blk_nxt_s[BW-1:0] = bus.data_in;
              idx_nxt_s         = IW'(1);
              if (!bus.info_in[7] || (BLOCKS == 1)) begin
                state_nxt_s = ST_PUSH;
              end else begin
                state_nxt_s = ST_COLLECT;
              end
            end
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (accept_s) begin
          for (int b = 0; b < BLOCKS; b++) begin
            if (idx_r == IW'(b)) begin
              blk_nxt_s[b*BW +: BW] = bus.data_in;
            end else begin
              blk_nxt_s[b*BW +: BW] = blk_r[b*BW +: BW];
            end
          end
          idx_nxt_s = idx_r + IW'(1);
          if (idx_r == IW'(BLOCKS - 1)) begin
            state_nxt_s = ST_PUSH;
          end else begin
            state_nxt_s = ST_COLLECT;
          end
        end else begin
          state_nxt_s = ST_COLLECT;
        end
      end
      ST_PUSH: begin
        if (push_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_PUSH;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, packet assembly registers and sticky error flags.
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state_r      <= ST_IDLE;
      info_r       <= 8'd0;
      count_r      <= 8'd0;
      exp_r        <= 8'd0;
      blk_r        <= '0;
      idx_r        <= '0;
      err_count_r  <= 1'b0;
      err_mode_r   <= 1'b0;
      err_dir_r    <= 1'b0;
      data_ready_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      info_r       <= info_nxt_s;
      count_r      <= count_nxt_s;
      exp_r        <= exp_nxt_s;
      blk_r        <= blk_nxt_s;
      idx_r        <= idx_nxt_s;
      err_count_r  <= err_count_nxt_s;
      err_mode_r   <= err_mode_nxt_s;
      err_dir_r    <= err_dir_nxt_s;
      data_ready_r <= (state_nxt_s != ST_PUSH);
    end
  end

  // Shift-register FIFO: entry 0 is the head, so the output is a flop.
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      fifo_up_s[i] = fifo_r[i+1];
    end
    fifo_up_s[DEPTH-1] = '0;
    wr_idx_s = pop_s ? (level_r - LW'(1)) : level_r;
    for (int i = 0; i < DEPTH; i++) begin
      if (push_s && (wr_idx_s == LW'(i))) begin
        fifo_nxt_s[i] = pkt_s;
      end else if (pop_s) begin
        fifo_nxt_s[i] = fifo_up_s[i];
      end else begin
        fifo_nxt_s[i] = fifo_r[i];
      end
    end
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // FIFO storage, occupancy and head-valid registers.
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_r[i] <= '0;
      end
      level_r     <= '0;
      pkt_valid_r <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_r[i] <= fifo_nxt_s[i];
      end
      level_r     <= level_nxt_s;
      pkt_valid_r <= (level_nxt_s != LW'(0));
    end
  end

  assign bus.data_ready = data_ready_r;
  assign bus.pkt_valid  = pkt_valid_r;
  assign bus.pkt_out    = fifo_r[0];
  assign err_count      = err_count_r;
  assign err_mode       = err_mode_r;
  assign err_dir        = err_dir_r;
  assign level          = level_r;

endmodule

// File: tb/tb_simon_pkt_out_fifo.sv
// Scoreboard testbench for simon_pkt_out_fifo: expected packets are queued as
// headers are driven and compared when the DUT hands a packet downstream.
module tb_simon_pkt_out_fifo;
  localparam int         N      = 16;
  localparam int         BLOCKS = 2;
  localparam int         DEPTH  = 2;
  localparam logic [3:0] MODE   = 4'h0;
  localparam int         PW     = 16 + BLOCKS * 2 * N;

  logic       clk = 1'b0;
  logic       nR = 1'b0;
  logic       err_clr = 1'b0;
  logic       err_count, err_mode, err_dir;
  logic [1:0] level;

  simon_pkt_out_fifo_if #(.N(N), .BLOCKS(BLOCKS)) bus ();

  simon_pkt_out_fifo #(.N(N), .BLOCKS(BLOCKS), .DEPTH(DEPTH), .MODE(MODE)) u_dut (
    .clk       (clk),
    .nR        (nR),
    .bus       (bus),
    .err_clr   (err_clr),
    .err_count (err_count),
    .err_mode  (err_mode),
    .err_dir   (err_dir),
    .level     (level)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [PW-1:0] sb[$];
  logic [PW-1:0] mon_exp;
  logic [7:0]    tb_exp = 8'd0;

  // Scoreboard monitor: every handshake on the packet side pops one expected packet.
  always @(negedge clk) begin
    if (nR && bus.pkt_valid && bus.pkt_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pkt_unexpected: got %h, none expected", bus.pkt_out);
      end else begin
        mon_exp = sb.pop_front();
        if (bus.pkt_out !== mon_exp) begin
          errors++;
          $display("FAIL pkt_data: got %h, expected %h", bus.pkt_out, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic beat(input logic [7:0] info, input logic [7:0] cnt, input logic [31:0] d);
    logic acc;
    acc = 1'b0;
    bus.data_valid = 1'b1;
    bus.info_in    = info;
    bus.count_in   = cnt;
    bus.data_in    = d;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = bus.data_ready;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL beat_timeout: data_ready=0, expected 1 within 100 cycles");
    end
  endtask

  task automatic send_pkt(input logic [7:0] info, input logic [7:0] cnt,
                          input logic [31:0] b0, input logic [31:0] b1);
    logic [31:0] e0, e1;
    bit          good;
    good = (cnt == tb_exp) && (info[3:0] == MODE) && info[4];
    beat(info, cnt, b0);
    if (good) begin
      if (info[5]) begin
        e0 = 32'd0; e1 = 32'd0;
      end else if (info[7]) begin
        e0 = b0; e1 = b1;
        beat(8'h00, 8'hFF, b1);
      end else begin
        e0 = b0; e1 = 32'd0;
      end
      sb.push_back({info, cnt, e1, e0});
      tb_exp++;
    end
    bus.data_valid = 1'b0;
  endtask

  task automatic drain();
    bus.pkt_ready = 1'b1;
    for (int k = 0; k < 60 && (sb.size() != 0 || bus.pkt_valid !== 1'b0); k++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (sb.size() != 0 || bus.pkt_valid !== 1'b0 || level !== 2'd0) begin
      errors++;
      $display("FAIL drain: pending=%0d pkt_valid=%b level=%0d, expected 0 0 0",
               sb.size(), bus.pkt_valid, level);
    end
    bus.pkt_ready = 1'b0;
  endtask

  task automatic test_reset();
    nR = 1'b0;
    bus.data_valid = 1'b0; bus.data_in = '0; bus.info_in = '0; bus.count_in = '0;
    bus.pkt_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.data_ready, bus.pkt_valid, err_count, err_mode, err_dir} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 00000",
               {bus.data_ready, bus.pkt_valid, err_count, err_mode, err_dir});
    end
    checks++;
    if (bus.pkt_out !== '0 || level !== 2'd0) begin
      errors++;
      $display("FAIL reset_fifo: pkt_out=%h level=%0d, expected 0 0", bus.pkt_out, level);
    end
    @(posedge clk); #1;
    nR = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.data_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_pre: got %b, expected 0", bus.data_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.data_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_post: got %b, expected 1", bus.data_ready);
    end
  endtask

  task automatic test_two_block();
    bus.pkt_ready = 1'b0;
    send_pkt(8'h90, 8'h00, 32'hA1A2A3A4, 32'h05060708);
    @(negedge clk);
    checks++;
    if (bus.data_ready !== 1'b0 || bus.pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL two_block_push: ready=%b valid=%b, expected 0 0", bus.data_ready, bus.pkt_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.data_ready !== 1'b1 || bus.pkt_valid !== 1'b1 || level !== 2'd1) begin
      errors++;
      $display("FAIL two_block_write: ready=%b valid=%b level=%0d, expected 1 1 1",
               bus.data_ready, bus.pkt_valid, level);
    end
    checks++;
    if (bus.pkt_out !== 80'h90_00_05060708_A1A2A3A4) begin
      errors++;
      $display("FAIL two_block_data: got %h, expected 900005060708a1a2a3a4", bus.pkt_out);
    end
    drain();
  endtask

  task automatic test_single_null();
    send_pkt(8'h10, 8'h01, 32'h11223344, 32'h55667788);
    send_pkt(8'h30, 8'h02, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(posedge clk); #1;
    checks++;
    if (level !== 2'd2) begin
      errors++;
      $display("FAIL single_null_level: got %0d, expected 2", level);
    end
    drain();
  endtask

  task automatic test_errors();
    send_pkt(8'h90, 8'h05, 32'h1, 32'h2);
    checks++;
    if ({err_count, err_mode, err_dir} !== 3'b100 || bus.data_ready !== 1'b1 || level !== 2'd0) begin
      errors++;
      $display("FAIL err_count: flags=%b ready=%b level=%0d, expected 100 1 0",
               {err_count, err_mode, err_dir}, bus.data_ready, level);
    end
    send_pkt(8'h91, 8'h03, 32'h3, 32'h4);
    checks++;
    if ({err_count, err_mode, err_dir} !== 3'b110) begin
      errors++;
      $display("FAIL err_mode: flags=%b, expected 110", {err_count, err_mode, err_dir});
    end
    send_pkt(8'h80, 8'h03, 32'h5, 32'h6);
    checks++;
    if ({err_count, err_mode, err_dir} !== 3'b111) begin
      errors++;
      $display("FAIL err_dir: flags=%b, expected 111", {err_count, err_mode, err_dir});
    end
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    checks++;
    if ({err_count, err_mode, err_dir} !== 3'b000) begin
      errors++;
      $display("FAIL err_clr: flags=%b, expected 000", {err_count, err_mode, err_dir});
    end
    err_clr = 1'b1;
    send_pkt(8'h10, 8'h09, 32'h7, 32'h8);
    err_clr = 1'b0;
    checks++;
    if ({err_count, err_mode, err_dir} !== 3'b100) begin
      errors++;
      $display("FAIL err_clr_vs_set: flags=%b, expected 100", {err_count, err_mode, err_dir});
    end
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    send_pkt(8'h10, 8'h03, 32'hCAFEF00D, 32'h0);
    drain();
    checks++;
    if ({err_count, err_mode, err_dir} !== 3'b000) begin
      errors++;
      $display("FAIL err_after_good: flags=%b, expected 000", {err_count, err_mode, err_dir});
    end
  endtask

  task automatic test_backpressure();
    bus.pkt_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      send_pkt(8'h10, tb_exp, 32'hB000_0000 + 32'(i), 32'h0);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.data_ready !== 1'b0 || level !== 2'd2) begin
        errors++;
        $display("FAIL bp_hold: ready=%b level=%0d, expected 0 2", bus.data_ready, level);
      end
    end
    @(posedge clk); #1;
    bus.pkt_ready = 1'b1;
    @(posedge clk); #1;
    bus.pkt_ready = 1'b0;
    checks++;
    if (level !== 2'd2 || bus.pkt_valid !== 1'b1 || bus.data_ready !== 1'b1 || sb.size() != 2) begin
      errors++;
      $display("FAIL bp_push_pop: level=%0d valid=%b ready=%b pending=%0d, expected 2 1 1 2",
               level, bus.pkt_valid, bus.data_ready, sb.size());
    end
    drain();
  endtask

  task automatic test_count_wrap();
    nR = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    tb_exp = 8'd0;
    nR = 1'b1;
    bus.pkt_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      send_pkt(8'h10, 8'(i), 32'(i * 3), 32'h0);
    end
    drain();
    checks++;
    if (err_count !== 1'b0 || tb_exp !== 8'd1) begin
      errors++;
      $display("FAIL wrap_no_error: err_count=%b model_exp=%0d, expected 0 1", err_count, tb_exp);
    end
  endtask

  task automatic test_reset_mid();
    bus.pkt_ready = 1'b0;
    send_pkt(8'h10, tb_exp, 32'h0BAD0BAD, 32'h0);
    @(posedge clk); #1;
    beat(8'h90, tb_exp, 32'hDEAD0001);
    checks++;
    if (level !== 2'd1 || bus.data_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: level=%0d ready=%b, expected 1 1", level, bus.data_ready);
    end
    bus.data_valid = 1'b0;
    nR = 1'b0;
    #1;
    checks++;
    if (level !== 2'd0 || bus.pkt_valid !== 1'b0 || bus.data_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: level=%0d valid=%b ready=%b, expected 0 0 0",
               level, bus.pkt_valid, bus.data_ready);
    end
    sb.delete();
    tb_exp = 8'd0;
    @(posedge clk); #1;
    nR = 1'b1;
    send_pkt(8'h90, 8'h00, 32'h12345678, 32'h9ABCDEF0);
    drain();
    checks++;
    if ({err_count, err_mode, err_dir} !== 3'b000) begin
      errors++;
      $display("FAIL mid_after: flags=%b, expected 000", {err_count, err_mode, err_dir});
    end
  endtask

  initial begin
    test_reset();
    test_two_block();
    test_single_null();
    test_errors();
    test_backpressure();
    test_count_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
